variance_ctrl: RTL and testbench
================================

VARIANCE_CTRL -- requirements
Module: variance_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: pixel width; the variance datapath result is 2*WIDTH.
REQ-002 Parameter IMG_WIDTH, default 8: pixels per line.
REQ-003 Parameter IMG_HEIGHT, default 8: lines per frame; INPUT_NUM = IMG_WIDTH*IMG_HEIGHT.
REQ-004 Parameter CALC_LATENCY, default 3: compute cycles from last accumulate to valid datapath result; legal range 1..15.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to process one frame.
REQ-008 abort  input  1  cancel the current frame.
REQ-009 s_valid  input  1  upstream pixel valid.
REQ-010 s_ready  output  1  upstream pixel ready.
REQ-011 s_data  input  WIDTH  upstream pixel.
REQ-012 dp_clear  output  1  datapath accumulator clear (drives datapath reset).
REQ-013 dp_data  output  WIDTH  pixel to datapath.
REQ-014 dp_accum_en  output  1  datapath accumulate strobe.
REQ-015 dp_compute  output  1  datapath compute strobe (drives datapath data_valid).
REQ-016 dp_variance  input  2*WIDTH  datapath variance result.
REQ-017 dp_mean  input  WIDTH  datapath mean result.
REQ-018 res_valid  output  1  result available.
REQ-019 res_ready  input  1  result consumer ready.
REQ-020 res_variance  output  2*WIDTH  captured variance.
REQ-021 res_mean  output  WIDTH  captured mean.
REQ-022 busy  output  1  high in any state except IDLE.
REQ-023 frame_count  output  16  completed frames (result handshakes), wraps 0xFFFF->0.
REQ-024 err_start  output  1  sticky flag: start seen while not IDLE.

Function
REQ-025 FSM states: IDLE, CLEAR, ACCUM, COMPUTE, HOLD, one-hot or binary at implementer's choice.
REQ-026 IDLE: s_ready=0; start=1 -> CLEAR next cycle.
REQ-027 CLEAR: exactly one cycle, dp_clear=1, pixel counter <- 0, compute counter <- 0 -> ACCUM.
REQ-028 ACCUM: s_ready=1; transfer = s_valid & s_ready; dp_accum_en = transfer, combinational; dp_data = s_data, combinational.
REQ-029 Pixel counter, width clog2(INPUT_NUM+1), increments on each transfer; transfer with counter = INPUT_NUM-1 -> COMPUTE; counter never exceeds INPUT_NUM.
REQ-030 s_valid low in ACCUM: hold state and counter, no timeout.
REQ-031 COMPUTE: s_ready=0, dp_accum_en=0, dp_compute=1 for exactly CALC_LATENCY consecutive cycles; in the last one, res_variance <- dp_variance, res_mean <- dp_mean -> HOLD.
REQ-032 HOLD: res_valid=1, res_variance/res_mean stable; res_valid & res_ready -> frame_count+1 and IDLE.
REQ-033 HOLD handshake with start=1 in the same cycle -> CLEAR directly (back-to-back frame), no err_start.
REQ-034 start in any state other than IDLE (except REQ-033 case) is ignored and sets err_start.
REQ-035 abort=1 in any state -> IDLE next cycle, res_valid=0, counters cleared, frame_count unchanged; abort overrides start and res_ready in the same cycle.
REQ-036 dp_clear, dp_accum_en, dp_compute mutually exclusive; all 0 in IDLE and HOLD.
REQ-037 res_variance/res_mean keep last captured value after leaving HOLD until next capture.

Reset
REQ-038 reset=0 at a rising edge -> state IDLE, pixel/compute counters 0, res_valid 0, res_variance 0, res_mean 0, frame_count 0, err_start 0, dp_clear 1 (datapath cleared under reset), s_ready 0, dp_accum_en 0, dp_compute 0.
REQ-039 Reset mid-frame behaves as REQ-038 regardless of state; first start after release starts a fresh frame.

Verification
REQ-040 Default params, start, 64 pixels value 5 with s_valid always 1 -> exactly 64 dp_accum_en pulses, 3 dp_compute cycles, res_mean/res_variance equal dp values at capture, res_valid held until res_ready, frame_count=1.
REQ-041 Pixels with s_valid toggling 1010... -> still exactly 64 transfers, COMPUTE entered one cycle after 64th transfer, no dp_accum_en when s_valid=0.
REQ-042 start during ACCUM pixel 10 -> ignored, err_start=1 and sticky, frame completes normally.
REQ-043 abort at pixel 30 -> IDLE next cycle, busy=0, frame_count unchanged; next start runs full 64-pixel frame with one dp_clear.
REQ-044 res_ready=1 with start=1 in HOLD -> CLEAR next cycle, frame_count+1, err_start stays 0.
REQ-045 reset=0 during COMPUTE -> all outputs at REQ-038 values next cycle, frame_count=0.

Source files
------------

// File: rtl/variance_ctrl_if.sv
// Pixel stream, datapath and result bundle for variance_ctrl.
// slave = controller side, master = stream source / datapath / result sink.
interface variance_ctrl_if #(
  parameter int WIDTH = 8
);
  // upstream pixel stream
  logic               s_valid;
  logic               s_ready;
  logic [WIDTH-1:0]   s_data;
  // datapath control and results
  logic               dp_clear;
  logic [WIDTH-1:0]   dp_data;
  logic               dp_accum_en;
  logic               dp_compute;
  logic [2*WIDTH-1:0] dp_variance;
  logic [WIDTH-1:0]   dp_mean;
  // result handshake
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_variance;
  logic [WIDTH-1:0]   res_mean;

  modport slave (
    input  s_valid, s_data, dp_variance, dp_mean, res_ready,
    output s_ready, dp_clear, dp_data, dp_accum_en, dp_compute,
    output res_valid, res_variance, res_mean
  );

  modport master (
    output s_valid, s_data, dp_variance, dp_mean, res_ready,
    input  s_ready, dp_clear, dp_data, dp_accum_en, dp_compute,
    input  res_valid, res_variance, res_mean
  );
endinterface

// File: rtl/variance_ctrl.sv
// Frame sequencer for a variance datapath: clear, accumulate one frame of
// pixels, run compute for CALC_LATENCY cycles, then hold the result.
// Ports: clk, reset (sync, active-low), i_start, i_abort, io (slave:
// pixel stream, datapath strobes/results, result handshake), o_busy,
// o_frame_count (completed handshakes), o_err_start (sticky).
module variance_ctrl #(
  parameter int WIDTH        = 8,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int CALC_LATENCY = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_abort,
  variance_ctrl_if.slave  io,
  output logic            o_busy,
  output logic [15:0]     o_frame_count,
  output logic            o_err_start
);

  localparam int INPUT_NUM = IMG_WIDTH * IMG_HEIGHT;
  localparam int PCW       = $clog2(INPUT_NUM + 1);

  localparam logic [PCW-1:0] LAST_PIX  = PCW'(INPUT_NUM - 1);
  localparam logic [PCW-1:0] PIX_ONE   = PCW'(1);
  localparam logic [3:0]     LAST_CALC = 4'(CALC_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_COMPUTE,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic [PCW-1:0]     r_pix_cnt;
  logic [3:0]         r_calc_cnt;
  logic [2*WIDTH-1:0] r_variance;
  logic [WIDTH-1:0]   r_mean;
  logic [15:0]        r_frame_cnt;
  logic               r_err_start;

  logic w_accum;
  logic w_xfer;
  logic w_res_hs;
  logic w_start_err;

  assign w_accum  = (r_state == S_ACCUM);
  assign w_xfer   = io.s_valid & w_accum;
  assign w_res_hs = (r_state == S_HOLD) & io.res_ready;

  // A start that lands on the result handshake chains the next frame;
  // anywhere else outside IDLE it is a protocol error.
  assign w_start_err = i_start & (r_state != S_IDLE) & ~w_res_hs;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pix_cnt   <= '0;
      r_calc_cnt  <= '0;
      r_variance  <= '0;
      r_mean      <= '0;
      r_frame_cnt <= '0;
      r_err_start <= 1'b0;
    end else if (i_abort) begin
      r_state    <= S_IDLE;
      r_pix_cnt  <= '0;
      r_calc_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_pix_cnt  <= '0;
          r_calc_cnt <= '0;
          r_state    <= S_ACCUM;
        end
        S_ACCUM: begin
          if (w_xfer) begin
            r_pix_cnt <= r_pix_cnt + PIX_ONE;
            if (r_pix_cnt == LAST_PIX)
              r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (r_calc_cnt == LAST_CALC) begin
            r_variance <= io.dp_variance;
            r_mean     <= io.dp_mean;
            r_calc_cnt <= '0;
            r_state    <= S_HOLD;
          end else begin
            r_calc_cnt <= r_calc_cnt + 4'd1;
          end
        end
        S_HOLD: begin
          if (io.res_ready) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= i_start ? S_CLEAR : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_start_err) r_err_start <= 1'b1;
    end
  end

  // Datapath is held cleared for as long as reset is asserted.
  assign io.dp_clear     = ~reset | (r_state == S_CLEAR);
  assign io.dp_data      = io.s_data;
  assign io.dp_accum_en  = w_xfer;
  assign io.dp_compute   = (r_state == S_COMPUTE);
  assign io.s_ready      = w_accum;
  assign io.res_valid    = (r_state == S_HOLD);
  assign io.res_variance = r_variance;
  assign io.res_mean     = r_mean;

  assign o_busy        = (r_state != S_IDLE);
  assign o_frame_count = r_frame_cnt;
  assign o_err_start   = r_err_start;

endmodule

// File: tb/tb_variance_ctrl.sv
// Directed bench for variance_ctrl with a frame-level reference model
// compared on every falling edge.
module tb_variance_ctrl;
  localparam int W    = 8;
  localparam int LAT  = 3;
  localparam int NPIX = 64;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic [15:0] frame_count;
  logic        err_start;
  int          tick = 0;

  variance_ctrl_if #(.WIDTH(W)) vif ();

  variance_ctrl #(
    .WIDTH(W), .IMG_WIDTH(8), .IMG_HEIGHT(8), .CALC_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_start(start),
    .i_abort(abort),
    .io(vif.slave),
    .o_busy(busy),
    .o_frame_count(frame_count),
    .o_err_start(err_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  // datapath results change every cycle so capture timing is visible
  assign vif.dp_variance = 16'(32'h1234 + tick * 7);
  assign vif.dp_mean     = 8'(tick ^ 32'h5A);

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_comp = 0;
  int n_clr = 0;
  int b_acc, b_comp, b_clr;

  // reference model: phase 0 idle,1 clear,2 accum,3 compute,4 hold
  int          ph = 0;
  int          pix = 0;
  int          ccnt = 0;
  int          frames = 0;
  bit          err = 0;
  logic [15:0] mv = '0;
  logic [7:0]  mm = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  task automatic model_step();
    bit e_acc;
    e_acc = (ph == 2) && vif.s_valid;
    chk("s_ready", 32'(vif.s_ready), 32'(ph == 2));
    chk("dp_accum_en", 32'(vif.dp_accum_en), 32'(e_acc));
    if (e_acc) chk("dp_data", 32'(vif.dp_data), 32'(vif.s_data));
    chk("dp_clear", 32'(vif.dp_clear), 32'(!reset || ph == 1));
    chk("dp_compute", 32'(vif.dp_compute), 32'(ph == 3));
    chk("res_valid", 32'(vif.res_valid), 32'(ph == 4));
    chk("res_variance", 32'(vif.res_variance), 32'(mv));
    chk("res_mean", 32'(vif.res_mean), 32'(mm));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("frame_count", 32'(frame_count), 32'(frames & 16'hFFFF));
    chk("err_start", 32'(err_start), 32'(err));
    if (vif.dp_accum_en) n_acc++;
    if (vif.dp_compute) n_comp++;
    if (vif.dp_clear) n_clr++;
    if (!reset) begin
      ph = 0; pix = 0; ccnt = 0; frames = 0; err = 0; mv = '0; mm = '0;
    end else if (abort) begin
      ph = 0; pix = 0; ccnt = 0;
    end else begin
      case (ph)
        0: if (start) ph = 1;
        1: begin
          ph = 2; pix = 0; ccnt = 0;
          if (start) err = 1;
        end
        2: begin
          if (start) err = 1;
          if (vif.s_valid) begin
            pix++;
            if (pix == NPIX) ph = 3;
          end
        end
        3: begin
          if (start) err = 1;
          ccnt++;
          if (ccnt == LAT) begin
            mv = vif.dp_variance; mm = vif.dp_mean; ph = 4; ccnt = 0;
          end
        end
        default: begin
          if (vif.res_ready) begin
            frames = (frames + 1) & 16'hFFFF;
            ph = start ? 1 : 0;
          end else if (start) err = 1;
        end
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic snap();
    b_acc = n_acc; b_comp = n_comp; b_clr = n_clr;
  endtask

  task automatic feed(input bit toggle, input bit const5,
                      input int start_at, input int abort_at);
    int  sent = 0;
    int  k = 0;
    bit  sdone = 0;
    bit  aborted = 0;
    while (sent < NPIX && k < 600 && !aborted) begin
      vif.s_valid = toggle ? (k % 2 == 0) : 1'b1;
      vif.s_data  = const5 ? 8'd5 : 8'(k * 13 + 3);
      if (!sdone && start_at >= 0 && sent == start_at && vif.s_ready) begin
        start = 1'b1;
        sdone = 1;
      end
      if (abort_at >= 0 && sent == abort_at) abort = 1'b1;
      @(negedge clk);
      if (vif.s_valid && vif.s_ready) sent++;
      cyc();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        aborted = 1;
      end
      k++;
    end
    vif.s_valid = 1'b0;
    if (k >= 600) fail_now("feed_timeout");
  endtask

  task automatic wait_result();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (vif.res_valid) break;
    end
    cyc();
    if (k >= 50) fail_now("result_timeout");
  endtask

  task automatic handshake(input bit with_start);
    repeat (3) cyc();
    vif.res_ready = 1'b1;
    start = with_start;
    cyc();
    vif.res_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    vif.s_valid = 1'b0;
    vif.s_data = '0;
    vif.res_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
    join_none

    // reset state
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dp_clear", 32'(vif.dp_clear), 1);
    chk("rst_frame_count", 32'(frame_count), 0);
    cyc();
    reset = 1'b1;
    cyc();

    // constant pixels, s_valid always high
    snap();
    pulse_start();
    feed(0, 1, -1, -1);
    wait_result();
    handshake(0);
    cyc();
    @(negedge clk);
    chk("t1_accum_pulses", 32'(n_acc - b_acc), 64);
    chk("t1_compute_cycles", 32'(n_comp - b_comp), 3);
    chk("t1_clear_pulses", 32'(n_clr - b_clr), 1);
    chk("t1_frame_count", 32'(frame_count), 1);
    chk("t1_err_start", 32'(err_start), 0);
    cyc();

    // s_valid toggling
    snap();
    pulse_start();
    feed(1, 0, -1, -1);
    wait_result();
    handshake(0);
    cyc();
    @(negedge clk);
    chk("t2_accum_pulses", 32'(n_acc - b_acc), 64);
    chk("t2_frame_count", 32'(frame_count), 2);
    cyc();

    // start during pixel 10
    pulse_start();
    feed(0, 0, 10, -1);
    @(negedge clk);
    chk("t3_err_mid", 32'(err_start), 1);
    cyc();
    wait_result();
    handshake(0);
    cyc();
    @(negedge clk);
    chk("t3_err_sticky", 32'(err_start), 1);
    chk("t3_frame_count", 32'(frame_count), 3);
    cyc();

    // abort at pixel 30, then a full frame
    pulse_start();
    feed(0, 0, -1, 30);
    @(negedge clk);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_frame_count", 32'(frame_count), 3);
    cyc();
    snap();
    pulse_start();
    feed(0, 0, -1, -1);
    wait_result();
    handshake(0);
    cyc();
    @(negedge clk);
    chk("t4_accum_pulses", 32'(n_acc - b_acc), 64);
    chk("t4_clear_pulses", 32'(n_clr - b_clr), 1);
    chk("t4_frame_count", 32'(frame_count), 4);
    cyc();

    // back-to-back frame via start on handshake
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    pulse_start();
    feed(0, 0, -1, -1);
    wait_result();
    handshake(1);
    @(negedge clk);
    chk("t5_dp_clear", 32'(vif.dp_clear), 1);
    chk("t5_frame_count", 32'(frame_count), 1);
    chk("t5_err_start", 32'(err_start), 0);
    cyc();
    feed(0, 0, -1, -1);
    wait_result();
    handshake(0);
    cyc();
    @(negedge clk);
    chk("t5_frame_count2", 32'(frame_count), 2);
    chk("t5_err_start2", 32'(err_start), 0);
    cyc();

    // reset during COMPUTE
    pulse_start();
    feed(0, 0, -1, -1);
    begin
      int k;
      for (k = 0; k < 10; k++) begin
        @(negedge clk);
        if (vif.dp_compute) break;
      end
      if (k >= 10) fail_now("compute_timeout");
    end
    cyc();
    reset = 1'b0;
    cyc();
    @(negedge clk);
    chk("t6_frame_count", 32'(frame_count), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_dp_compute", 32'(vif.dp_compute), 0);
    chk("t6_dp_clear", 32'(vif.dp_clear), 1);
    chk("t6_res_variance", 32'(vif.res_variance), 0);
    chk("t6_s_ready", 32'(vif.s_ready), 0);
    cyc();
    reset = 1'b1;
    cyc();
    snap();
    pulse_start();
    feed(0, 1, -1, -1);
    wait_result();
    handshake(0);
    cyc();
    @(negedge clk);
    chk("t6_fresh_accum", 32'(n_acc - b_acc), 64);
    chk("t6_fresh_frames", 32'(frame_count), 1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
